// File: rtl/mem_router.sv
// CPU-side memory request router: decodes one request against NUM_TGT base/mask regions
// and runs a strobe/ack handshake to the selected target. Optional macro: MEM_ROUTER_TIMEOUT_EN.
module mem_router #(
   parameter int unsigned                NUM_TGT  = 4,
   parameter int unsigned                ADDR_W   = 32,
   parameter int unsigned                DATA_W   = 32,
   parameter logic [NUM_TGT*ADDR_W-1:0]  TGT_BASE = '0,
   parameter logic [NUM_TGT*ADDR_W-1:0]  TGT_MASK = '0,
   parameter int unsigned                TIMEOUT  = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         data_i,
   input  logic [DATA_W/8-1:0]       be,
   input  logic                      ren,
   input  logic                      wen,
   output logic                      ack,
   output logic                      err,
   output logic [DATA_W-1:0]         data_o,
   output logic [ADDR_W-1:0]         t_addr,
   output logic [DATA_W-1:0]         t_data_i,
   output logic [DATA_W/8-1:0]       t_be,
   output logic [NUM_TGT-1:0]        t_ren,
   output logic [NUM_TGT-1:0]        t_wen,
   input  logic [NUM_TGT*DATA_W-1:0] t_data_o,
   input  logic [NUM_TGT-1:0]        t_ack
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_q, rd_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                ack_d, err_d;
   logic [DATA_W-1:0]   data_d, wdata_d;
   logic [ADDR_W-1:0]   off_d;
   logic [BE_W-1:0]     be_d;
   logic [NUM_TGT-1:0]  ren_d, wen_d;
   logic                hit;
   logic [SEL_W-1:0]    hit_idx;
   logic [ADDR_W-1:0]   hit_off;

`ifdef MEM_ROUTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   assign cnt_inc = cnt_q + CNT_W'(1);
`endif

   // Region decode; scanning downwards lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_off = '0;
      for (int i = int'(NUM_TGT) - 1; i >= 0; i--) begin
         if ((addr_q & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
            hit_off = addr_q & ~TGT_MASK[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Next state and next register values.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      sel_d   = sel_q;
      ack_d   = ack;
      err_d   = err;
      data_d  = data_o;
      off_d   = t_addr;
      wdata_d = t_data_i;
      be_d    = t_be;
      ren_d   = t_ren;
      wen_d   = t_wen;
`ifdef MEM_ROUTER_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (ren || wen) begin
               addr_d  = addr;
               wdata_d = data_i;
               be_d    = be;
               rd_d    = ren;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (hit) begin
               sel_d = hit_idx;
               off_d = hit_off;
               if (rd_q) ren_d = NUM_TGT'(1) << hit_idx;
               else      wen_d = NUM_TGT'(1) << hit_idx;
`ifdef MEM_ROUTER_TIMEOUT_EN
               cnt_d = '0;
`endif
               state_d = ACCESS;
            end else begin
               ack_d   = 1'b1;
               err_d   = 1'b1;
               data_d  = '0;
               state_d = DONE;
            end
         end
         ACCESS: begin
            if (t_ack[sel_q]) begin
               ren_d   = '0;
               wen_d   = '0;
               ack_d   = 1'b1;
               err_d   = 1'b0;
               if (rd_q) data_d = t_data_o[sel_q*DATA_W +: DATA_W];
               state_d = DONE;
            end
`ifdef MEM_ROUTER_TIMEOUT_EN
            else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               ren_d   = '0;
               wen_d   = '0;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               data_d  = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_inc;
            end
`endif
         end
         DONE: begin
            if (!ren && !wen) begin
               ack_d   = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         sel_q    <= '0;
         ack      <= 1'b0;
         err      <= 1'b0;
         data_o   <= '0;
         t_addr   <= '0;
         t_data_i <= '0;
         t_be     <= '0;
         t_ren    <= '0;
         t_wen    <= '0;
`ifdef MEM_ROUTER_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         sel_q    <= sel_d;
         ack      <= ack_d;
         err      <= err_d;
         data_o   <= data_d;
         t_addr   <= off_d;
         t_data_i <= wdata_d;
         t_be     <= be_d;
         t_ren    <= ren_d;
         t_wen    <= wen_d;
`ifdef MEM_ROUTER_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_router.sv
// Randomised self-checking bench for mem_router against a region-table reference model.
// Timeout scenarios are exercised when MEM_ROUTER_TIMEOUT_EN is defined.
module tb_mem_router;

   localparam int unsigned TO_CYC = 8;
   localparam logic [31:0] B0 = 32'h0000_0000, M0 = 32'hF000_0000;
   localparam logic [31:0] B1 = 32'h1FC0_0000, M1 = 32'hFFF8_0000;
   localparam logic [31:0] B2 = 32'h2000_0000, M2 = 32'hF000_0000;
   localparam logic [31:0] B3 = 32'h0000_0000, M3 = 32'hFF00_0000;

   logic [31:0] base_a [4] = '{B0, B1, B2, B3};
   logic [31:0] mask_a [4] = '{M0, M1, M2, M3};

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  addr, data_i, data_o, t_addr, t_data_i;
   logic [3:0]   be, t_be, t_ren, t_wen, t_ack;
   logic         ren, wen, ack, err;
   logic [127:0] t_data_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_data = '0;

   mem_router #(
      .NUM_TGT(4), .ADDR_W(32), .DATA_W(32),
      .TGT_BASE({B3, B2, B1, B0}), .TGT_MASK({M3, M2, M1, M0}),
      .TIMEOUT(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_i(data_i), .be(be),
      .ren(ren), .wen(wen), .ack(ack), .err(err), .data_o(data_o),
      .t_addr(t_addr), .t_data_i(t_data_i), .t_be(t_be),
      .t_ren(t_ren), .t_wen(t_wen), .t_data_o(t_data_o), .t_ack(t_ack)
   );

   always #5 clk = ~clk;

   // Reference decode: first region in the table whose masked bits equal its base.
   function automatic int ref_decode(input logic [31:0] a);
      for (int i = 0; i < 4; i++)
         if ((a & mask_a[i]) == base_a[i]) return i;
      return -1;
   endfunction

   // One CPU transaction; dly = ACCESS cycle index (0-based) in which the target acks.
   task automatic run_txn(input string name, input logic [31:0] a, input bit rd,
                          input logic [31:0] wd, input logic [3:0] b, input int dly,
                          input logic [31:0] tdata, input int hold);
      int tg;
      bit done, to;
      logic [3:0]  strb;
      logic [31:0] off;
      tg = ref_decode(a);
      addr = a; data_i = wd; be = b; ren = rd;
      wen = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      addr = $urandom; data_i = $urandom; be = 4'($urandom);
      total++;
      if (ack !== 1'b0 || t_ren !== 4'b0 || t_wen !== 4'b0) begin
         bad++; $display("FAIL %s decode_quiet ack=%b t_ren=%b t_wen=%b want 0", name, ack, t_ren, t_wen);
      end
      @(posedge clk); #1;
      if (tg < 0) begin
         exp_data = '0;
         total++;
         if (ack !== 1'b1 || err !== 1'b1 || data_o !== 32'h0 || t_ren !== 4'b0 || t_wen !== 4'b0) begin
            bad++; $display("FAIL %s unmapped ack=%b err=%b data_o=%h strobes=%b/%b want 1/1/0/0", name, ack, err, data_o, t_ren, t_wen);
         end
      end else begin
         strb = 4'b0001 << tg;
         off  = a & ~mask_a[tg];
         done = 1'b0;
         for (int i = 0; i < 64 && !done; i++) begin
            total++;
            if (t_ren !== (rd ? strb : 4'b0) || t_wen !== (rd ? 4'b0 : strb) || ack !== 1'b0 ||
                t_addr !== off || t_data_i !== wd || t_be !== b) begin
               bad++; $display("FAIL %s access[%0d] t_ren=%b t_wen=%b ack=%b t_addr=%h t_data_i=%h t_be=%b want %b %b 0 %h %h %b",
                               name, i, t_ren, t_wen, ack, t_addr, t_data_i, t_be,
                               rd ? strb : 4'b0, rd ? 4'b0 : strb, off, wd, b);
            end
            t_data_o = {$urandom, $urandom, $urandom, $urandom};
            t_data_o[tg*32 +: 32] = tdata;
            t_ack = (4'($urandom) & ~strb) | ((i == dly) ? strb : 4'b0);
            @(posedge clk); #1;
            t_ack = 4'b0;
`ifdef MEM_ROUTER_TIMEOUT_EN
            to = (i != dly) && (i + 1 == int'(TO_CYC));
`else
            to = 1'b0;
`endif
            if (i == dly || to) begin
               done = 1'b1;
               if (to) exp_data = '0;
               else if (rd) exp_data = tdata;
               total++;
               if (ack !== 1'b1 || err !== to || data_o !== exp_data || t_ren !== 4'b0 || t_wen !== 4'b0) begin
                  bad++; $display("FAIL %s complete ack=%b err=%b data_o=%h strobes=%b/%b want 1/%b/%h/0", name, ack, err, data_o, t_ren, t_wen, to, exp_data);
               end
            end
         end
         total++;
         if (!done) begin
            bad++; $display("FAIL %s no_completion done=%b want 1", name, done);
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         total++;
         if (ack !== 1'b1 || data_o !== exp_data || t_ren !== 4'b0 || t_wen !== 4'b0) begin
            bad++; $display("FAIL %s hold[%0d] ack=%b data_o=%h strobes=%b/%b want 1/%h/0", name, h, ack, data_o, t_ren, t_wen, exp_data);
         end
      end
      ren = 1'b0; wen = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ack !== 1'b0 || err !== 1'b0 || data_o !== exp_data) begin
         bad++; $display("FAIL %s release ack=%b err=%b data_o=%h want 0/0/%h", name, ack, err, data_o, exp_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; data_i = '0; be = '0;
      t_ack = '0; t_data_o = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ack, err, data_o, t_ren, t_wen, t_addr, t_data_i, t_be} !== '0) begin
         bad++; $display("FAIL reset ack=%b err=%b data_o=%h t_ren=%b t_wen=%b t_addr=%h want all 0", ack, err, data_o, t_ren, t_wen, t_addr);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read_hit();
      run_txn("read_hit", 32'h1FC0_0010, 1'b1, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
   endtask

   task automatic test_write_be();
      run_txn("write_be", 32'h2000_0abc, 1'b0, 32'h1234_5678, 4'b0011, 5, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_overlap_unmapped();
      run_txn("overlap", 32'h0012_3450, 1'b1, 32'h0, 4'hF, 2, 32'hA5A5_0001, 0);
      run_txn("unmapped", 32'h8000_0040, 1'b1, 32'h0, 4'hF, 0, 32'h0, 0);
      run_txn("unmapped_wr", 32'hC123_0000, 1'b0, 32'h5555_AAAA, 4'hF, 0, 32'h0, 1);
   endtask

   task automatic test_hold();
      run_txn("hold", 32'h1FC7_FFFC, 1'b1, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 10);
   endtask

   task automatic test_timeout();
`ifdef MEM_ROUTER_TIMEOUT_EN
      run_txn("timeout", 32'h2000_0000, 1'b1, 32'h0, 4'hF, 1000, 32'h1111_2222, 2);
      run_txn("ack_on_last", 32'h2000_0004, 1'b1, 32'h0, 4'hF, int'(TO_CYC) - 1, 32'h3333_4444, 0);
      run_txn("timeout_wr", 32'h0500_0000, 1'b0, 32'h7777_8888, 4'b1000, 1000, 32'h0, 0);
`else
      run_txn("long_wait", 32'h2000_0000, 1'b1, 32'h0, 4'hF, 20, 32'h1111_2222, 0);
`endif
   endtask

   task automatic test_random();
      logic [31:0] a;
      int pick;
      for (int n = 0; n < 40; n++) begin
         pick = $urandom_range(0, 4);
         case (pick)
            0: a = 32'h0000_0000 | (32'($urandom) & 32'h0FFF_FFFF);
            1: a = B1 | (32'($urandom) & ~M1);
            2: a = B2 | (32'($urandom) & ~M2);
            3: a = 32'h0000_0000 | (32'($urandom) & 32'h00FF_FFFF);
            default: a = 32'h3000_0000 | 32'($urandom);
         endcase
         run_txn("random", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                 $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
      end
   endtask

   task automatic test_mid_reset();
      addr = 32'h2000_0100; ren = 1'b1; wen = 1'b0; data_i = '0; be = 4'hF;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (t_ren !== 4'b0100) begin
         bad++; $display("FAIL mid_reset_pre t_ren=%b want 0100", t_ren);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({ack, err, data_o, t_ren, t_wen, t_addr, t_data_i, t_be} !== '0) begin
         bad++; $display("FAIL mid_reset ack=%b err=%b data_o=%h t_ren=%b t_wen=%b t_addr=%h want all 0", ack, err, data_o, t_ren, t_wen, t_addr);
      end
      rst = 1'b1; ren = 1'b0; exp_data = '0;
      @(posedge clk); #1;
      run_txn("after_reset", 32'h1FC0_0020, 1'b1, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 0);
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_be();
      test_overlap_unmapped();
      test_hold();
      test_timeout();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised successor to the CPU-side address interpreter. It decodes one CPU memory request against `NUM_TGT` base/mask regions and forwards it to exactly one target port over a uniform strobe/ack handshake. It returns the read data, or an error for unmapped or timed-out accesses, and holds `ack` until the CPU releases the request. It sits between the CPU memory port and the BIOS ROM, SDRAM bridge, scratch pad and HW-register blocks, so new regions can be added without touching the FSM.

## Interface
Parameters:
- `NUM_TGT`, 4 — number of target ports, 1..16
- `ADDR_W`, 32 — address width
- `DATA_W`, 32 — data width, multiple of 8
- `TGT_BASE`, {`NUM_TGT`{`ADDR_W`'h0}} — packed bases; target i is at bits [i*ADDR_W +: ADDR_W]
- `TGT_MASK`, {`NUM_TGT`{`ADDR_W`'h0}} — packed masks; 1 marks a decoded bit
- `TIMEOUT`, 255 — maximum ACCESS cycles without `t_ack`, ≥1

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous and active-low
- `addr`  in  ADDR_W  CPU address
- `data_i`  in  DATA_W  CPU write data
- `be`  in  DATA_W/8  CPU byte enables
- `ren`, `wen`  in  1  CPU read and write requests
- `ack`  out  1  transaction complete
- `err`  out  1  error status, valid while `ack`=1
- `data_o`  out  DATA_W  read data
- `t_addr`  out  ADDR_W  offset, `addr_q & ~TGT_MASK[sel]`
- `t_data_i`  out  DATA_W  latched write data
- `t_be`  out  DATA_W/8  latched byte enables
- `t_ren`, `t_wen`  out  NUM_TGT  one-hot strobes
- `t_data_o`  in  NUM_TGT*DATA_W  packed target read data
- `t_ack`  in  NUM_TGT  per-target acknowledge

## Operation
The FSM has four states: IDLE, DECODE, ACCESS, DONE.

- **IDLE**
  - On `ren` or `wen`: latch `addr`, `data_i`, `be` and the operation, then go to DECODE.
  - If `ren` and `wen` are both high, the operation is a read.
- **DECODE**
  - Target i hits when `(addr_q & TGT_MASK[i]) == TGT_BASE[i]`.
  - If several targets hit, the lowest index wins.
  - On a hit: register `sel` and go to ACCESS.
  - On no hit: set `ack`=1, `err`=1, `data_o`=0, and go to DONE.
- **ACCESS**
  - Drive `t_ren[sel]` or `t_wen[sel]` high, steady, until `t_ack[sel]` is sampled high.
  - On that edge:
    - For reads, `data_o` ← `t_data_o[sel]`.
    - Set `ack`=1 and `err`=0.
    - The strobe drops and the FSM goes to DONE.
  - `t_ack` from targets other than `sel` is ignored.
- **DONE**
  - Hold `ack`, `err` and `data_o`.
  - When `ren`=0 and `wen`=0: clear `ack` and `err`, and go to IDLE.
- **General rules**
  - CPU inputs that change after the IDLE latch are ignored.
  - Writes never modify `data_o`.
  - `t_addr`, `t_data_i` and `t_be` come from the latched copies and are stable for the whole transaction.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM goes to IDLE.
  - `ack`, `err`, `data_o`, `t_ren`, `t_wen`, `t_addr`, `t_data_i` and `t_be` all go to 0.
  - The timeout counter goes to 0.
  - Reset mid-transaction drops the access; strobes are low the cycle after the edge.
- Latency, with the request sampled at edge 0:
  - DECODE in cycle 1.
  - Strobe high in cycle 2.
  - If `t_ack` is first sampled at edge k (k ≥ 3), `ack` is high from cycle k.
  - Best case, with the target acking in cycle 2, `ack` is high in cycle 3.
  - Unmapped address: `ack`/`err` high in cycle 2.
- Strobes are one-hot or zero and are registered.
- After release, the earliest next request is accepted in IDLE one cycle after `ack` falls.
- `ren`/`wen` held high in DONE keep the FSM in DONE, so there is no re-issue.

## Configuration
Macro `MEM_ROUTER_TIMEOUT_EN`:
- **Defined:**
  - A counter of width clog2(`TIMEOUT`+1) clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches `TIMEOUT` without `t_ack[sel]`, the strobe drops, `ack`=1, `err`=1, `data_o`=0, and the FSM goes to DONE.
  - If `t_ack[sel]` and expiry occur in the same cycle, the ack wins: normal completion with `err`=0.
- **Not defined:** there is no counter, and ACCESS waits indefinitely for `t_ack`.

## Test plan
- Read hit: `NUM_TGT`=4, T1 base 32'h1FC0_0000, mask 32'hFFF8_0000. CPU reads 32'h1FC0_0010; T1 acks in cycle 2 with 32'hDEAD_BEEF.
  - `t_ren`=4'b0010 and `t_addr`=32'h10 in cycle 2.
  - `ack`=1, `err`=0, `data_o`=32'hDEAD_BEEF in cycle 3.
- Write with byte enables: write 32'h1234_5678 with `be`=4'b0011 to T2; T2 acks after 5 cycles.
  - `t_wen`=4'b0100, `t_data_i`=32'h1234_5678, `t_be`=4'b0011 are held throughout.
  - `ack` rises one edge after `t_ack`, and `data_o` is unchanged.
- Overlap and unmapped: T0 and T3 both match the address, so `t_ren`=4'b0001.
  - A separate address matching no target gives `ack`=1, `err`=1, `data_o`=0 in cycle 2, with no strobe.
- Timeout: with `MEM_ROUTER_TIMEOUT_EN` defined and `TIMEOUT`=8, the target never acks.
  - After 8 ACCESS cycles, `err`=1 and `ack`=1.
  - In a repeat where `t_ack` arrives on the 8th cycle, `err`=0.
- Hold and reset: `ren` held high for 10 cycles after `ack` gives exactly one `t_ren` pulse train.
  - When `ren` drops, `ack` drops on the next edge.
  - Asserting `rst`=0 mid-ACCESS drives all outputs to 0 on the next edge.
